crc_frame_check: RTL

Receive-side CRC checker for the 48-bit link frame: 32-bit payload followed by a 16-bit CRC, sent MSB-first as a serial bit stream. It sits directly downstream of the transmit serialiser, or of the deinterleave/decode stage on the receive path. It consumes one bit per qualified clock and runs a CRC-16/XMODEM division over all 48 bits. It then presents the captured payload with a pass/fail flag and keeps a saturating count of failed frames.

---
 rtl/crc_pkg.sv | 26 ++
 rtl/crc16_serial_step.sv | 29 ++
 rtl/crc_frame_check.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_pkg
// Description : Shared constants and state encoding for the serial CRC-16
//               link frame (receive checker and transmit generator).
// Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

  // CRC-16/XMODEM generator (x^16 implicit) and preset value
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  // Default frame layout: payload first, CRC last
  localparam int DEF_DATA_BITS = 32;
  localparam int DEF_CRC_BITS  = 16;
  localparam int FRAME_BITS    = DEF_DATA_BITS + DEF_CRC_BITS;

  // Frame receive state, explicit 1-bit encoding
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc16_serial_step.sv
`default_nettype none
// ============================================================================
// Module      : crc16_serial_step
// Description : Combinational single-bit MSB-first LFSR update. Shared
//               between the transmit CRC generator and the receive checker.
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_serial_step
  import crc_pkg::*;
#(
  parameter int CRC_BITS = DEF_CRC_BITS
) (
  input  logic [CRC_BITS-1:0] crc_in,
  input  logic                data_bit,
  input  logic [CRC_BITS-1:0] poly,
  output logic [CRC_BITS-1:0] crc_out
);

  logic w_feedback;

  // Feedback is the outgoing MSB combined with the incoming bit; when set,
  // the shifted register is reduced by the generator polynomial.
  always_comb begin
    w_feedback = crc_in[CRC_BITS-1] ^ data_bit;
    crc_out    = {crc_in[CRC_BITS-2:0], 1'b0} ^ (w_feedback ? poly : '0);
  end

endmodule : crc16_serial_step
`default_nettype wire

// File: rtl/crc_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : crc_frame_check
// Description : Receive-side CRC checker for the serial link frame. Accepts
//               one qualified bit per clock, divides the whole frame by the
//               CRC polynomial, reports the payload with a pass/fail flag and
//               keeps a saturating count of failed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_frame_check
  import crc_pkg::*;
#(
  parameter int                DATA_BITS = DEF_DATA_BITS,
  parameter int                CRC_BITS  = DEF_CRC_BITS,
  parameter logic [CRC_BITS-1:0] POLY    = CRC16_POLY,
  parameter logic [CRC_BITS-1:0] INIT    = CRC16_INIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 crc_ok,
  output logic [DATA_BITS-1:0] data_out,
  output logic [15:0]          err_cnt
);

  localparam int TOTAL_BITS = DATA_BITS + CRC_BITS;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  localparam logic [CNT_W-1:0] c_data_bits = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(TOTAL_BITS - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [15:0]      c_err_max   = 16'hFFFF;

  state_t                r_state;
  state_t                w_state_next;
  logic [CRC_BITS-1:0]   r_crc;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0]  r_payload;
  logic                  r_frame_done;
  logic                  r_crc_ok;
  logic [DATA_BITS-1:0]  r_data_out;
  logic [15:0]           r_err_cnt;

  logic                  w_accept;
  logic                  w_last;
  logic [CRC_BITS-1:0]   w_crc_base;
  logic [CRC_BITS-1:0]   w_crc_next;
  logic [CNT_W-1:0]      w_cnt_base;
  logic                  w_crc_zero;

  // A start restarts the division from the preset value, so a bit arriving
  // with start is processed against INIT rather than the stale register.
  always_comb begin
    w_crc_base = start ? INIT : r_crc;
    w_cnt_base = start ? '0 : r_bit_cnt;
    w_accept   = in_valid && (start || (r_state == RECV));
    // Completion never fires on a start cycle: a new frame always wins.
    w_last     = w_accept && !start && (r_state == RECV) && (r_bit_cnt == c_last_bit);
    w_crc_zero = (w_crc_next == '0);
  end

  crc16_serial_step #(
    .CRC_BITS (CRC_BITS)
  ) u_step (
    .crc_in   (w_crc_base),
    .data_bit (in_bit),
    .poly     (POLY),
    .crc_out  (w_crc_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: start always (re)enters RECV, final bit returns to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RECV;
        end
      end
      RECV: begin
        if (start) begin
          w_state_next = RECV;
        end else if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // CRC register, bit counter and payload shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc     <= INIT;
      r_bit_cnt <= '0;
      r_payload <= '0;
    end else begin
      if (w_accept) begin
        r_crc     <= w_crc_next;
        r_bit_cnt <= w_cnt_base + c_cnt_one;
        if (w_cnt_base < c_data_bits) begin
          r_payload <= {r_payload[DATA_BITS-2:0], in_bit};
        end
      end else if (start) begin
        r_crc     <= INIT;
        r_bit_cnt <= '0;
      end
    end
  end

  // Frame result capture and saturating failed-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_data_out   <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= w_last;
      if (w_last) begin
        r_crc_ok   <= w_crc_zero;
        r_data_out <= r_payload;
        if (!w_crc_zero && (r_err_cnt != c_err_max)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign busy       = (r_state == RECV);
  assign frame_done = r_frame_done;
  assign crc_ok     = r_crc_ok;
  assign data_out   = r_data_out;
  assign err_cnt    = r_err_cnt;

endmodule : crc_frame_check
`default_nettype wire
